// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   IF stage of the 5-stage MIPS pipeline. Owns the PC, issues inst_sram
//   reads, takes redirects from ID, and keeps an instruction hold buffer so a
//   synchronous-SRAM word returned while ID is stalled is not lost.
//   Also keeps free-running fetch/redirect event counters.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   stall            pipeline stall vector (bit0=IF, bit1=ID, ...), 1=stop
//   br_bus           {br_e, br_addr[31:0]} from ID, same-cycle
//   inst_sram_*      instruction SRAM request (read-only) and read data
//   if_to_id_bus     {ce, pc} handed to the ID pipeline register
//   id_inst          instruction for ID: hold buffer or live SRAM data
//   fetch_cnt        accepted fetches
//   redirect_cnt     taken redirects
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          STALL_W  = 6,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [32:0]        br_bus,
    output logic               inst_sram_en,
    output logic [3:0]         inst_sram_wen,
    output logic [31:0]        inst_sram_addr,
    output logic [31:0]        inst_sram_wdata,
    input  logic [31:0]        inst_sram_rdata,
    output logic [32:0]        if_to_id_bus,
    output logic [31:0]        id_inst,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   redirect_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t      state;
    logic        ce;
    logic [31:0] pc;
    logic        hold_valid;
    logic [31:0] hold_inst;
    logic        rvalid;    // SRAM word for the previous request is present
    logic        id_ce;     // ce as captured by the ID pipeline register

    logic        br_e;
    logic [31:0] br_addr;
    logic [31:0] next_pc;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign next_pc = br_e ? br_addr : pc + 32'd4;

    // Only IF and ID stall bits matter here.
    logic unused_stall;
    assign unused_stall = &{1'b0, stall[STALL_W-1:2]};

    assign inst_sram_en    = ce & ~rst;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = pc;
    assign inst_sram_wdata = 32'b0;
    assign if_to_id_bus    = rst ? 33'b0 : {ce, pc};
    assign id_inst         = !id_ce     ? 32'b0 :
                             hold_valid ? hold_inst : inst_sram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ce           <= 1'b0;
            pc           <= RESET_PC - 32'd4;
            hold_valid   <= 1'b0;
            hold_inst    <= 32'b0;
            rvalid       <= 1'b0;
            id_ce        <= 1'b0;
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            rvalid <= inst_sram_en & ~stall[0];
            // ID register only loads when ID itself is not stalled.
            if (!stall[1])
                id_ce <= ce;

            case (state)
                IDLE: begin
                    if (!stall[0]) begin
                        ce    <= 1'b1;
                        pc    <= RESET_PC;
                        state <= RUN;
                    end
                end
                RUN, HOLD: begin
                    // A redirect is only honoured when IF advances; one seen
                    // under stall[0] must be re-presented by ID.
                    if (!stall[0]) begin
                        pc           <= next_pc;
                        fetch_cnt    <= fetch_cnt + CNT_W'(1);
                        redirect_cnt <= redirect_cnt + CNT_W'(br_e);
                    end
                    // Capture the returning word while ID cannot consume it;
                    // once held it is not overwritten until ID releases.
                    if (state == RUN && stall[1] && rvalid) begin
                        hold_inst  <= inst_sram_rdata;
                        hold_valid <= 1'b1;
                        state      <= HOLD;
                    end else if (state == HOLD && !stall[1]) begin
                        hold_valid <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
